ec_error_monitor18x10: RTL and testbench



---
 rtl/ec_pkg.sv | 22 ++
 rtl/ec_valid_delay.sv | 33 +++
 rtl/ec_error_monitor18x10.sv | 196 +++++++++++++++++++
 tb/tb_ec_error_monitor18x10.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ec_pkg.sv
// Shared types and constants for the RNS error-correction monitor.
//   EC_NUM_DIG / EC_DIG_W : digit count and digit width of a corrected word
//   ec_digit_t            : one corrected digit
//   ec_mon_state_t        : snapshot FSM state
//   SNAP_*_BIT            : bit positions inside snap_code
package ec_pkg;
  localparam int EC_NUM_DIG = 10;
  localparam int EC_DIG_W   = 18;

  // Largest legal snapshot select; anything above reads back as zero.
  localparam logic [3:0] EC_SEL_MAX = 4'(EC_NUM_DIG - 1);

  typedef logic [EC_DIG_W-1:0] ec_digit_t;

  typedef enum logic {
    ARMED    = 1'b0,
    CAPTURED = 1'b1
  } ec_mon_state_t;

  localparam int SNAP_NC_BIT  = 0;
  localparam int SNAP_MAL_BIT = 1;
endpackage

// File: rtl/ec_valid_delay.sv
// Fixed-depth 1-bit delay line used to regenerate a valid for pipe stages
// that carry none.
//   clk, reset : clock, async active-high reset (flushes the line)
//   d_i        : valid entering the pipe
//   q_o        : d_i delayed by DEPTH cycles
module ec_valid_delay #(
  parameter int DEPTH = 81
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  generate
    if (DEPTH == 1) begin : g_one
      logic vld_q;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) vld_q <= 1'b0;
        else       vld_q <= d_i;
      end
      assign q_o = vld_q;
    end else begin : g_many
      logic [DEPTH-1:0] vld_pipe_q;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) vld_pipe_q <= '0;
        else       vld_pipe_q <= {vld_pipe_q[DEPTH-2:0], d_i};
      end
      assign q_o = vld_pipe_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/ec_error_monitor18x10.sv
// Error monitor behind the 18-bit x 10-digit RNS corrector.
// Re-times the corrected word with a regenerated valid, counts correction
// events (saturating), raises a sticky alarm on uncorrectable events and
// freezes the first uncorrectable word for host readout.
//   clk, reset        : clock, async active-high reset
//   valid_in          : valid aligned with the corrector's input digits
//   in_0_..in_9_      : corrected digits (aligned with the delayed valid)
//   cor_error, non_cor_error, mal_error : corrector flags
//   clr_stats         : sync clear of counters, alarm and snapshot
//   snap_sel          : snapshot digit select
//   out_0_..out_9_, out_valid, out_cor, out_uncorr : registered word
//   cor_count, non_cor_count, mal_count : saturating event counters
//   alarm             : sticky threshold alarm
//   snap_valid, snap_code, snap_dig     : frozen snapshot readout
module ec_error_monitor18x10
  import ec_pkg::*;
#(
  parameter int PIPE_LAT     = 81,
  parameter int CNT_W        = 16,
  parameter int ALARM_THRESH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                valid_in,
  input  logic [EC_DIG_W-1:0] in_0_,
  input  logic [EC_DIG_W-1:0] in_1_,
  input  logic [EC_DIG_W-1:0] in_2_,
  input  logic [EC_DIG_W-1:0] in_3_,
  input  logic [EC_DIG_W-1:0] in_4_,
  input  logic [EC_DIG_W-1:0] in_5_,
  input  logic [EC_DIG_W-1:0] in_6_,
  input  logic [EC_DIG_W-1:0] in_7_,
  input  logic [EC_DIG_W-1:0] in_8_,
  input  logic [EC_DIG_W-1:0] in_9_,
  input  logic                cor_error,
  input  logic                non_cor_error,
  input  logic                mal_error,
  input  logic                clr_stats,
  input  logic [3:0]          snap_sel,
  output logic [EC_DIG_W-1:0] out_0_,
  output logic [EC_DIG_W-1:0] out_1_,
  output logic [EC_DIG_W-1:0] out_2_,
  output logic [EC_DIG_W-1:0] out_3_,
  output logic [EC_DIG_W-1:0] out_4_,
  output logic [EC_DIG_W-1:0] out_5_,
  output logic [EC_DIG_W-1:0] out_6_,
  output logic [EC_DIG_W-1:0] out_7_,
  output logic [EC_DIG_W-1:0] out_8_,
  output logic [EC_DIG_W-1:0] out_9_,
  output logic                out_valid,
  output logic                out_cor,
  output logic                out_uncorr,
  output logic [CNT_W-1:0]    cor_count,
  output logic [CNT_W-1:0]    non_cor_count,
  output logic [CNT_W-1:0]    mal_count,
  output logic                alarm,
  output logic                snap_valid,
  output logic [1:0]          snap_code,
  output logic [EC_DIG_W-1:0] snap_dig
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W:0]   THRESH  = (CNT_W+1)'(ALARM_THRESH);

  // ---------------------------------------------------------------- valid
  logic v_al;

  ec_valid_delay #(.DEPTH(PIPE_LAT)) u_vdly (
    .clk   (clk),
    .reset (reset),
    .d_i   (valid_in),
    .q_o   (v_al)
  );

  ec_digit_t dig_in [EC_NUM_DIG];
  assign dig_in = '{in_0_, in_1_, in_2_, in_3_, in_4_,
                    in_5_, in_6_, in_7_, in_8_, in_9_};

  // Flags are only meaningful on an aligned word.
  logic evt_cor, evt_nc, evt_mal, evt_unc;
  assign evt_cor = v_al & cor_error;
  assign evt_nc  = v_al & non_cor_error;
  assign evt_mal = v_al & mal_error;
  assign evt_unc = evt_nc | evt_mal;

  // --------------------------------------------------------- output stage
  ec_digit_t out_q [EC_NUM_DIG];
  logic      out_valid_q, out_cor_q, out_uncorr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      out_cor_q    <= 1'b0;
      out_uncorr_q <= 1'b0;
      out_q        <= '{default: '0};
    end else begin
      out_valid_q <= v_al;
      if (v_al) begin
        out_cor_q    <= cor_error;
        out_uncorr_q <= non_cor_error | mal_error;
        out_q        <= dig_in;
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign out_cor    = out_cor_q;
  assign out_uncorr = out_uncorr_q;
  assign out_0_ = out_q[0];
  assign out_1_ = out_q[1];
  assign out_2_ = out_q[2];
  assign out_3_ = out_q[3];
  assign out_4_ = out_q[4];
  assign out_5_ = out_q[5];
  assign out_6_ = out_q[6];
  assign out_7_ = out_q[7];
  assign out_8_ = out_q[8];
  assign out_9_ = out_q[9];

  // ------------------------------------------- stats, alarm and snapshot
  ec_mon_state_t    state_q, state_d;
  logic [CNT_W-1:0] cor_cnt_q, cor_cnt_d;
  logic [CNT_W-1:0] nc_cnt_q, nc_cnt_d;
  logic [CNT_W-1:0] mal_cnt_q, mal_cnt_d;
  logic             alarm_q, alarm_d;
  logic [1:0]       snap_code_q, snap_code_d;
  ec_digit_t        snap_q [EC_NUM_DIG];
  ec_digit_t        snap_d [EC_NUM_DIG];
  logic [CNT_W:0]   err_sum;

  always_comb begin
    state_d     = state_q;
    cor_cnt_d   = cor_cnt_q;
    nc_cnt_d    = nc_cnt_q;
    mal_cnt_d   = mal_cnt_q;
    alarm_d     = alarm_q;
    snap_code_d = snap_code_q;
    snap_d      = snap_q;
    err_sum     = '0;

    if (clr_stats) begin
      // Clear wins over a coincident event: it is neither counted nor captured.
      state_d     = ARMED;
      cor_cnt_d   = '0;
      nc_cnt_d    = '0;
      mal_cnt_d   = '0;
      alarm_d     = 1'b0;
      snap_code_d = '0;
      snap_d      = '{default: '0};
    end else begin
      if (evt_cor && cor_cnt_q != '1) cor_cnt_d = cor_cnt_q + CNT_ONE;
      if (evt_nc  && nc_cnt_q  != '1) nc_cnt_d  = nc_cnt_q  + CNT_ONE;
      if (evt_mal && mal_cnt_q != '1) mal_cnt_d = mal_cnt_q + CNT_ONE;

      // Alarm looks at the post-update counts so it rises with the word.
      err_sum = {1'b0, nc_cnt_d} + {1'b0, mal_cnt_d};
      if (err_sum >= THRESH) alarm_d = 1'b1;

      if (state_q == ARMED && evt_unc) begin
        state_d                  = CAPTURED;
        snap_d                   = dig_in;
        snap_code_d[SNAP_NC_BIT]  = non_cor_error;
        snap_code_d[SNAP_MAL_BIT] = mal_error;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ARMED;
      cor_cnt_q   <= '0;
      nc_cnt_q    <= '0;
      mal_cnt_q   <= '0;
      alarm_q     <= 1'b0;
      snap_code_q <= '0;
      snap_q      <= '{default: '0};
    end else begin
      state_q     <= state_d;
      cor_cnt_q   <= cor_cnt_d;
      nc_cnt_q    <= nc_cnt_d;
      mal_cnt_q   <= mal_cnt_d;
      alarm_q     <= alarm_d;
      snap_code_q <= snap_code_d;
      snap_q      <= snap_d;
    end
  end

  assign cor_count     = cor_cnt_q;
  assign non_cor_count = nc_cnt_q;
  assign mal_count     = mal_cnt_q;
  assign alarm         = alarm_q;
  assign snap_valid    = (state_q == CAPTURED);
  assign snap_code     = snap_code_q;
  assign snap_dig      = (snap_sel <= EC_SEL_MAX) ? snap_q[snap_sel] : '0;

endmodule

// File: tb/tb_ec_error_monitor18x10.sv
// Directed bench for ec_error_monitor18x10 with a scoreboard of expected
// output words; counters use a narrow width so saturation is reachable.
module tb_ec_error_monitor18x10;

  localparam int PIPE_LAT = 81;
  localparam int CNT_W    = 3;
  localparam int CMAX     = 7;
  localparam int THRESH   = 4;

  typedef struct packed {
    logic [9:0][17:0] d;
    logic cor, nc, mal, clr;
  } word_t;

  typedef struct packed {
    logic [9:0][17:0] d;
    logic       cor, unc;
    logic [2:0] cc, nc, mc;
    logic       alarm, snapv;
    logic [1:0] code;
  } exp_t;

  logic clk = 1'b0;
  logic reset, valid_in, cor_error, non_cor_error, mal_error, clr_stats;
  logic [3:0]  snap_sel;
  logic [17:0] din [10];
  logic [17:0] dout [10];
  logic out_valid, out_cor, out_uncorr, alarm, snap_valid;
  logic [CNT_W-1:0] cor_count, non_cor_count, mal_count;
  logic [1:0]  snap_code;
  logic [17:0] snap_dig;

  int n_vec = 0;
  int n_err = 0;

  word_t stim[$];
  exp_t  sb[$];

  // reference model state
  int m_cc, m_nc, m_mc;
  bit m_alarm, m_snapv;
  logic [9:0][17:0] m_snap;
  logic [1:0] m_code;

  always #5 clk = ~clk;

  ec_error_monitor18x10 #(.PIPE_LAT(PIPE_LAT), .CNT_W(CNT_W), .ALARM_THRESH(THRESH)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in),
    .in_0_(din[0]), .in_1_(din[1]), .in_2_(din[2]), .in_3_(din[3]), .in_4_(din[4]),
    .in_5_(din[5]), .in_6_(din[6]), .in_7_(din[7]), .in_8_(din[8]), .in_9_(din[9]),
    .cor_error(cor_error), .non_cor_error(non_cor_error), .mal_error(mal_error),
    .clr_stats(clr_stats), .snap_sel(snap_sel),
    .out_0_(dout[0]), .out_1_(dout[1]), .out_2_(dout[2]), .out_3_(dout[3]), .out_4_(dout[4]),
    .out_5_(dout[5]), .out_6_(dout[6]), .out_7_(dout[7]), .out_8_(dout[8]), .out_9_(dout[9]),
    .out_valid(out_valid), .out_cor(out_cor), .out_uncorr(out_uncorr),
    .cor_count(cor_count), .non_cor_count(non_cor_count), .mal_count(mal_count),
    .alarm(alarm), .snap_valid(snap_valid), .snap_code(snap_code), .snap_dig(snap_dig)
  );

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0][17:0] pack_out();
    logic [9:0][17:0] p;
    for (int k = 0; k < 10; k++) p[k] = dout[k];
    return p;
  endfunction

  task automatic model_clear();
    m_cc = 0; m_nc = 0; m_mc = 0;
    m_alarm = 1'b0; m_snapv = 1'b0; m_snap = '0; m_code = 2'b00;
  endtask

  // Applies one aligned word to the model and queues its expected output.
  task automatic model_word(input word_t w);
    exp_t e;
    if (w.clr) model_clear();
    else begin
      if (w.cor && m_cc < CMAX) m_cc++;
      if (w.nc  && m_nc < CMAX) m_nc++;
      if (w.mal && m_mc < CMAX) m_mc++;
      if (m_nc + m_mc >= THRESH) m_alarm = 1'b1;
      if (!m_snapv && (w.nc || w.mal)) begin
        m_snapv = 1'b1; m_snap = w.d; m_code = {w.mal, w.nc};
      end
    end
    e.d = w.d; e.cor = w.cor; e.unc = w.nc | w.mal;
    e.cc = 3'(m_cc); e.nc = 3'(m_nc); e.mc = 3'(m_mc);
    e.alarm = m_alarm; e.snapv = m_snapv; e.code = m_code;
    sb.push_back(e);
  endtask

  task automatic drive_word(input word_t w);
    for (int k = 0; k < 10; k++) din[k] = w.d[k];
    cor_error = w.cor; non_cor_error = w.nc; mal_error = w.mal; clr_stats = w.clr;
  endtask

  // Issues stim as back-to-back valids, presents each word PIPE_LAT cycles
  // later (where the corrector would emit it) and checks the outputs.
  task automatic run_burst();
    int n;
    exp_t e;
    word_t z;
    n = stim.size();
    z = '0;
    for (int c = 0; c < n + PIPE_LAT + 2; c++) begin
      @(negedge clk);
      if (c >= PIPE_LAT + 1 && c < PIPE_LAT + 1 + n) begin
        e = sb.pop_front();
        chk("out_valid", out_valid, 1'b1);
        chk("out_dig", pack_out(), e.d);
        chk("out_cor", out_cor, e.cor);
        chk("out_uncorr", out_uncorr, e.unc);
        chk("cor_count", cor_count, e.cc);
        chk("non_cor_count", non_cor_count, e.nc);
        chk("mal_count", mal_count, e.mc);
        chk("alarm", alarm, e.alarm);
        chk("snap_valid", snap_valid, e.snapv);
        chk("snap_code", snap_code, e.code);
      end else begin
        chk("idle_out_valid", out_valid, 1'b0);
      end
      valid_in = (c < n);
      if (c >= PIPE_LAT && c < PIPE_LAT + n) begin
        drive_word(stim[c - PIPE_LAT]);
        model_word(stim[c - PIPE_LAT]);
      end else drive_word(z);
    end
    stim.delete();
  endtask

  task automatic do_clear();
    @(negedge clk); clr_stats = 1'b1;
    @(negedge clk); clr_stats = 1'b0;
    model_clear();
  endtask

  task automatic chk_snap(input string tag);
    for (int k = 0; k < 10; k++) begin
      snap_sel = 4'(k); #1;
      chk(tag, snap_dig, m_snap[k]);
    end
    snap_sel = 4'd10; #1; chk("snap_sel10", snap_dig, 18'd0);
    snap_sel = 4'd15; #1; chk("snap_sel15", snap_dig, 18'd0);
    snap_sel = 4'd0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_vld"}, out_valid, 1'b0);
    chk({tag, "_cor"}, out_cor, 1'b0);
    chk({tag, "_unc"}, out_uncorr, 1'b0);
    chk({tag, "_dig"}, pack_out(), '0);
    chk({tag, "_cc"}, cor_count, 3'd0);
    chk({tag, "_nc"}, non_cor_count, 3'd0);
    chk({tag, "_mc"}, mal_count, 3'd0);
    chk({tag, "_alarm"}, alarm, 1'b0);
    chk({tag, "_snapv"}, snap_valid, 1'b0);
    chk({tag, "_code"}, snap_code, 2'b00);
    snap_sel = 4'd0; #1;
    chk({tag, "_snapdig"}, snap_dig, 18'd0);
  endtask

  function automatic word_t rnd_word(input logic cor, input logic nc, input logic mal, input logic clr);
    word_t w;
    for (int k = 0; k < 10; k++) w.d[k] = 18'($urandom);
    w.cor = cor; w.nc = nc; w.mal = mal; w.clr = clr;
    return w;
  endfunction

  initial begin
    word_t w;
    reset = 1'b1; valid_in = 1'b0; cor_error = 1'b0; non_cor_error = 1'b0;
    mal_error = 1'b0; clr_stats = 1'b0; snap_sel = 4'd0;
    for (int k = 0; k < 10; k++) din[k] = '0;
    model_clear();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk_all_zero("rst");

    // single clean word: out_valid pulses PIPE_LAT+1 cycles after valid_in
    stim.push_back(rnd_word(0, 0, 0, 0));
    run_burst();

    // correctable burst
    for (int i = 0; i < 5; i++) stim.push_back(rnd_word(1, 0, 0, 0));
    run_burst();
    chk("burst_cor_count", cor_count, 3'd5);

    // uncorrectable capture: word A is digits 1..10, word B is malformed
    for (int k = 0; k < 10; k++) w.d[k] = 18'(k + 1);
    w.cor = 0; w.nc = 1; w.mal = 0; w.clr = 0;
    stim.push_back(w);
    stim.push_back(rnd_word(0, 0, 1, 0));
    run_burst();
    chk_snap("snapA");
    snap_sel = 4'd3; #1; chk("snap_sel3", snap_dig, 18'd4);

    // alarm from four non_cor words, sticky afterwards
    do_clear();
    chk("clr_nc", non_cor_count, 3'd0);
    chk("clr_snapv", snap_valid, 1'b0);
    for (int i = 0; i < 4; i++) stim.push_back(rnd_word(0, 1, 0, 0));
    run_burst();
    repeat (5) @(negedge clk);
    chk("alarm_sticky", alarm, 1'b1);

    // clear colliding with an aligned mal word, then the next mal is captured
    stim.push_back(rnd_word(0, 0, 1, 1));
    for (int k = 0; k < 10; k++) w.d[k] = 18'(100 + k);
    w.cor = 0; w.nc = 0; w.mal = 1; w.clr = 0;
    stim.push_back(w);
    run_burst();
    chk_snap("snapB");

    // saturation
    do_clear();
    for (int i = 0; i < 9; i++) stim.push_back(rnd_word(1, 0, 0, 0));
    run_burst();
    chk("sat_cor_count", cor_count, 3'd7);

    // reset with words in flight: nothing emerges afterwards
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); valid_in = 1'b1;
    end
    reset = 1'b1;
    model_clear();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0; valid_in = 1'b0;
    for (int c = 0; c < PIPE_LAT + 20; c++) begin
      @(negedge clk);
      chk("post_rst_vld", out_valid, 1'b0);
      drive_word(rnd_word(1, 1, 1, 0));
    end
    drive_word('0);
    @(negedge clk);
    chk_all_zero("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
